// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Scan scheduler for the shared 4-digit 7-segment display. Time-multiplexes a
// single seg bus across four anodes, selects which page of watch digits is
// shown, and blinks the digits currently being edited. All scan timing is
// derived internally from clk.
//
// Parameters
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLINK_FRAMES  full frames per blink half-period (>= 1)
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low
//   digits     in   48-bit BCD {hr1,hr0,min1,min0,sec1,sec0,m1,m0,d1,d0,y1,y0}
//   page       in   0=hr:min 1=min:sec 2=month.day 3=year
//   edit_en    in   enable blinking of the digits selected by edit_mask
//   edit_mask  in   per-anode blink select, bit i <-> an[i]
//   an         out  anodes, active-low, an[3] = leftmost digit
//   seg        out  segments, active-low, {g,f,e,d,c,b,a}
//   dp         out  decimal point, active-low
//
// Configuration
//   LEADING_ZERO_BLANK_EN  when defined, page 0 blanks the leftmost digit
//                          while hr1 is zero.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 25000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] digits,
  input  logic [1:0]  page,
  input  logic        edit_en,
  input  logic [3:0]  edit_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Each slot is split into a one-cycle guard (all anodes off, so the old
  // segment pattern never leaks onto the new anode) followed by the display.
  typedef enum logic {PH_GUARD, PH_SHOW} phase_t;

  phase_t          phase_q, phase_d;
  logic [PW-1:0]   presc_q;
  logic [1:0]      slot_q;
  logic [FW-1:0]   frame_q;
  logic            blink_q;
  logic [1:0]      page_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  logic            tick;
  logic            load;
  logic [3:0]      nib_base;
  logic [3:0]      nib_idx;
  logic [5:0]      bit_idx;
  logic [3:0]      digit;
  logic            page_blank;
  logic            lz_blank;
  logic            blink_off;
  logic            an_on;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;  // non-BCD shows a dash
    endcase
  endfunction

  assign tick = (presc_q == PRESC_MAX);

  // Phase FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_GUARD;  // reset behaves like a guard: slot 0 loads next
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase FSM: next state and load strobe.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    phase_d = phase_q;
    load    = 1'b0;
    case (phase_q)
      PH_GUARD: begin
        phase_d = PH_SHOW;
        load    = 1'b1;
      end
      PH_SHOW: begin
        if (tick) phase_d = PH_GUARD;
      end
      default: phase_d = PH_GUARD;
    endcase
  end

  // Scan timing, page latch and blink timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= 2'd0;
      frame_q <= '0;
      blink_q <= 1'b0;
      page_q  <= 2'd0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        slot_q <= slot_q + 2'd1;
        // Page and blink only advance at frame boundaries, so one frame
        // never mixes two pages or two blink phases.
        if (slot_q == 2'd3) begin
          page_q <= page;
          if (frame_q == FRAME_MAX) begin
            frame_q <= '0;
            blink_q <= ~blink_q;
          end else begin
            frame_q <= frame_q + FW'(1);
          end
        end
      end
    end
  end

  // Digit routing: nibble index counted from y0 (0) up to hr1 (11). Each page
  // shows four consecutive nibbles, so the index is a page base plus slot.
  always_comb begin
    nib_base = 4'd0;
    case (page_q)
      2'd0: nib_base = 4'd8;   // hr1 hr0 min1 min0
      2'd1: nib_base = 4'd6;   // min1 min0 sec1 sec0
      2'd2: nib_base = 4'd2;   // m1 m0 d1 d0
      2'd3: nib_base = 4'd0;   // blank blank y1 y0
      default: nib_base = 4'd0;
    endcase
  end

  assign nib_idx = nib_base + {2'b00, slot_q};
  assign bit_idx = {nib_idx, 2'b00};
  assign digit   = digits[bit_idx +: 4];

  assign page_blank = (page_q == 2'd3) && slot_q[1];

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = (page_q == 2'd0) && (slot_q == 2'd3) && (digit == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  assign blink_off = edit_en && blink_q && edit_mask[slot_q];
  assign an_on     = !(page_blank || lz_blank || blink_off);

  assign an_d  = an_on ? ~(4'b0001 << slot_q) : AN_OFF;
  assign seg_d = an_on ? seg_decode(digit) : SEG_OFF;
  assign dp_d  = !(an_on && (slot_q == 2'd2) && (page_q != 2'd3));

  // Output registers: blanked on the tick edge (guard cycle), loaded from the
  // new slot on the guard edge, then held for the rest of the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else if (tick) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else if (load) begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
// Timing reference: k counts rising edges since the last reset release. Slot s
// of frame f is on display after edges 16f+4s+1 .. 16f+4s+3; edge 16f+4s is
// its guard edge, and edge 16f latches the page for frame f.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78,
                         S8 = 7'h00, S9 = 7'h10, DASH = 7'h3F, OFF = 7'h7F;

  localparam logic [47:0] D   = 48'h123456_112525;
  localparam logic [47:0] D3  = 48'h123456_11252C;
  localparam logic [47:0] D7  = 48'h789078_901234;
  localparam logic [47:0] DF  = 48'hF23456_112525;
  localparam logic [47:0] DZ  = 48'h094500_000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] digits;
  logic [1:0]  page;
  logic        edit_en;
  logic [3:0]  edit_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .page      (page),
    .edit_en   (edit_en),
    .edit_mask (edit_mask),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  typedef struct {
    string      name;
    logic [1:0] page;
    logic [47:0] digits;
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       chk_seg;
    logic       dp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (k=%0d, t=%0t)", name, got, exp, k, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic goto_k(input int target);
    while (k < target) step();
  endtask

  function automatic int blink_ph(input int f);
    return (f / 2) % 2;
  endfunction

  task automatic add_vec(input string name, input logic [1:0] p,
                         input logic [47:0] d, input int s, input logic [3:0] a,
                         input logic [6:0] sg, input logic cs, input logic dpv);
    vec_t v;
    v.name = name; v.page = p; v.digits = d; v.slot = s;
    v.an = a; v.seg = sg; v.chk_seg = cs; v.dp = dpv;
    vecs.push_back(v);
  endtask

  initial begin
    int f;
    int g;
    logic [3:0] low;
    logic       dplow;
    logic       multi;

    digits = D; page = 2'd0; edit_en = 1'b0; edit_mask = 4'b0000;

    // Directed table: inputs and hand-decoded expected outputs per slot.
    add_vec("p0_s3", 2'd0, D, 3, 4'b0111, S1, 1, 1);
    add_vec("p0_s2", 2'd0, D, 2, 4'b1011, S2, 1, 0);
    add_vec("p0_s1", 2'd0, D, 1, 4'b1101, S3, 1, 1);
    add_vec("p0_s0", 2'd0, D, 0, 4'b1110, S4, 1, 1);
    add_vec("p1_s3", 2'd1, D, 3, 4'b0111, S3, 1, 1);
    add_vec("p1_s2", 2'd1, D, 2, 4'b1011, S4, 1, 0);
    add_vec("p1_s1", 2'd1, D, 1, 4'b1101, S5, 1, 1);
    add_vec("p1_s0", 2'd1, D, 0, 4'b1110, S6, 1, 1);
    add_vec("p2_s3", 2'd2, D, 3, 4'b0111, S1, 1, 1);
    add_vec("p2_s2", 2'd2, D, 2, 4'b1011, S1, 1, 0);
    add_vec("p2_s1", 2'd2, D, 1, 4'b1101, S2, 1, 1);
    add_vec("p2_s0", 2'd2, D, 0, 4'b1110, S5, 1, 1);
    add_vec("p3_s3_blank", 2'd3, D3, 3, 4'b1111, OFF, 0, 1);
    add_vec("p3_s2_blank", 2'd3, D3, 2, 4'b1111, OFF, 0, 1);
    add_vec("p3_s1", 2'd3, D3, 1, 4'b1101, S2, 1, 1);
    add_vec("p3_s0_dash", 2'd3, D3, 0, 4'b1110, DASH, 1, 1);
    add_vec("d7_s3", 2'd0, D7, 3, 4'b0111, S7, 1, 1);
    add_vec("d7_s2", 2'd0, D7, 2, 4'b1011, S8, 1, 0);
    add_vec("d7_s1", 2'd0, D7, 1, 4'b1101, S9, 1, 1);
    add_vec("d7_s0", 2'd0, D7, 0, 4'b1110, S0, 1, 1);
    add_vec("hr1_dash", 2'd0, DF, 3, 4'b0111, DASH, 1, 1);
`ifdef LEADING_ZERO_BLANK_EN
    add_vec("hr1_zero", 2'd0, DZ, 3, 4'b1111, OFF, 0, 1);
`else
    add_vec("hr1_zero", 2'd0, DZ, 3, 4'b0111, S0, 1, 1);
`endif
    add_vec("hr0_nine", 2'd0, DZ, 2, 4'b1011, S9, 1, 0);

    // Reset state and first slot after release.
    #12;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, OFF);
    check("rst_dp", dp, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    check("guard_after_rst_an", an, 4'hF);
    step();
    check("first_an", an, 4'b1110);
    check("first_seg", seg, S4);
    goto_k(3);
    check("slot0_hold_an", an, 4'b1110);
    goto_k(4);
    check("tick_guard_an", an, 4'hF);
    goto_k(5);
    check("slot1_an", an, 4'b1101);
    check("slot1_seg", seg, S3);

    // Table-driven vectors: each waits for a frame whose page latch follows
    // the input change, then samples mid-slot.
    foreach (vecs[i]) begin
      page   = vecs[i].page;
      digits = vecs[i].digits;
      f = (k + 16) / 16;
      goto_k(16 * f + 4 * vecs[i].slot + 2);
      check({vecs[i].name, "_an"}, an, vecs[i].an);
      if (vecs[i].chk_seg) check({vecs[i].name, "_seg"}, seg, vecs[i].seg);
      check({vecs[i].name, "_dp"}, dp, vecs[i].dp);
    end

    // Page change 0 -> 2 in slot 1: rest of frame stays on page 0.
    page = 2'd0; digits = D;
    f = (k + 16) / 16;
    goto_k(16 * f + 5);
    page = 2'd2;
    goto_k(16 * f + 10);
    check("pgchg_s2_seg", seg, S2);
    goto_k(16 * f + 14);
    check("pgchg_s3_seg", seg, S1);
    goto_k(16 * (f + 1) + 2);
    check("pgchg_next_s0_seg", seg, S5);
    goto_k(16 * (f + 1) + 6);
    check("pgchg_next_s1_seg", seg, S2);
    goto_k(16 * (f + 1) + 10);
    check("pgchg_next_s2_seg", seg, S1);

    // Blink: mask 1100 on page 0 over 8 frames. Phase follows frames since
    // reset: two frames visible, two frames blanked.
    page = 2'd0; edit_en = 1'b1; edit_mask = 4'b1100;
    f = (k + 16) / 16;
    for (int fi = 0; fi < 8; fi++) begin
      goto_k(16 * (f + fi));
      low = 4'b0000; dplow = 1'b0; multi = 1'b0;
      for (int j = 0; j < 15; j++) begin
        step();
        low = low | ~an;
        if (!dp) dplow = 1'b1;
        if ($countones(~an) > 1) multi = 1'b1;
      end
      check($sformatf("blink_frame%0d", fi), {multi, dplow, low},
            (blink_ph(f + fi) == 1) ? {1'b0, 1'b0, 4'b0011}
                                    : {1'b0, 1'b1, 4'b1111});
    end

    // edit_en dropped mid-frame in a blanked frame: next slot shows again.
    f = (k + 16) / 16;
    while (blink_ph(f) != 1) f++;
    goto_k(16 * f + 6);
    check("edoff_s1_an", an, 4'b1101);
    edit_en = 1'b0;
    goto_k(16 * f + 10);
    check("edoff_s2_an", an, 4'b1011);
    check("edoff_s2_dp", dp, 1'b0);
    goto_k(16 * f + 14);
    check("edoff_s3_an", an, 4'b0111);
    // Phase kept running: the next blanked frame blanks again.
    edit_en = 1'b1;
    g = f + 1;
    while (blink_ph(g) != 1) g++;
    goto_k(16 * g + 10);
    check("edon_again_s2_an", an, 4'hF);
    check("edon_again_s2_dp", dp, 1'b1);
    edit_en = 1'b0;

    // Asynchronous reset pulse mid-slot while showing page 3.
    page = 2'd3; digits = D;
    f = (k + 16) / 16;
    goto_k(16 * f + 6);
    check("pre_rst_p3_s1_seg", seg, S2);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, OFF);
    check("async_rst_dp", dp, 1'b1);
    #0.5;
    rst_n = 1'b1;
    k = 0;
    step();
    check("restart_s0_an", an, 4'b1110);
    check("restart_s0_seg", seg, S4);
    goto_k(14);
    check("restart_p0_s3_an", an, 4'b0111);
    check("restart_p0_s3_seg", seg, S1);
    goto_k(16 + 14);
    check("restart_f1_p3_s3_an", an, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
